// File: rtl/udp_tx_packetizer_if.sv
// Stream bundles for the UDP TX packetizer: a plain valid/ready/data stream
// for descriptors and metadata, and a keep/last data stream for payload.
interface udp_stream_if #(
    parameter int DW = 160
) ();
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport master (output valid, data, input  ready);
    modport slave  (input  valid, data, output ready);
endinterface

interface udp_data_if #(
    parameter int WIDTH = 64
) ();
    logic               valid;
    logic               ready;
    logic [WIDTH-1:0]   data;
    logic [WIDTH/8-1:0] keep;
    logic               last;

    modport master (output valid, data, keep, last, input  ready);
    modport slave  (input  valid, data, keep, last, output ready);
endinterface

// File: rtl/udp_tx_packetizer.sv
// Store-and-forward UDP TX packetizer: buffers a whole payload, counts its
// bytes, then emits {length, descriptor} metadata and the buffered beats.
module udp_tx_packetizer #(
    parameter int WIDTH             = 64,
    parameter int DEPTH             = 512,
    parameter int MAX_PAYLOAD_BYTES = 1472,
    parameter int PKT_DEPTH         = 4
) (
    input  logic         net_clk,
    input  logic         net_aresetn,
    udp_stream_if.slave  s_axis_app_tx_dest,
    udp_data_if.slave    s_axis_app_tx_data,
    udp_stream_if.master m_axis_udp_tx_metadata,
    udp_data_if.master   m_axis_udp_tx_data,
    output logic [31:0]  drop_count
);
    localparam int KW = WIDTH / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int QW = $clog2(PKT_DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [KW-1:0]    keep;
        logic             last;
    } beat_t;

    typedef struct packed {
        logic [15:0]  len;
        logic [159:0] dest;
    } meta_t;

    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DROP = 2'd2} state_e;

    state_e        state_q, state_d;
    logic          run_q;

    beat_t         mem    [DEPTH];
    meta_t         dq_mem [PKT_DEPTH];
    beat_t         od_mem [2];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] pkt_start_q, pkt_start_d;
    logic [PW-1:0] commit_q, commit_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]   byte_cnt_q, byte_cnt_d, cnt_nxt;
    logic [159:0]  dest_q, dest_d;
    logic [31:0]   drop_q, drop_d;

    logic [QW:0]   dq_wp_q, dq_wp_d, dq_rp_q, dq_rp_d;
    logic [QW:0]   pkt_cnt_q, pkt_cnt_d;
    logic          mvld_q, mvld_d;
    meta_t         mdat_q, mdat_d;

    logic [1:0]    od_cnt_q, od_cnt_d;
    logic          od_wp_q, od_wp_d, od_rp_q, od_rp_d;

    logic          dest_rdy, data_rdy;
    logic          dest_hs, beat_hs, recv_beat, ovf, push;
    logic          buf_full, buf_empty, pkt_full, dq_nempty;
    logic          meta_load, meta_pop, rd_issue, od_pop;
    beat_t         in_beat;
    meta_t         push_meta;

    function automatic logic [15:0] popcnt(input logic [KW-1:0] k);
        popcnt = '0;
        for (int i = 0; i < KW; i++) popcnt = popcnt + 16'(k[i]);
    endfunction

    // Full counts the metadata output register too, so PKT_DEPTH bounds
    // every committed packet not yet handed to the stack.
    assign pkt_full  = (pkt_cnt_q == (QW+1)'(PKT_DEPTH));
    assign buf_full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    assign buf_empty = (rd_ptr_q == commit_q);
    assign dq_nempty = (dq_wp_q != dq_rp_q);

    assign dest_hs   = s_axis_app_tx_dest.valid && dest_rdy;
    assign beat_hs   = s_axis_app_tx_data.valid && data_rdy;
    assign recv_beat = beat_hs && (state_q == RECV);
    assign cnt_nxt   = byte_cnt_q + popcnt(s_axis_app_tx_data.keep);
    assign ovf       = (cnt_nxt > 16'(MAX_PAYLOAD_BYTES));
    assign push      = recv_beat && !ovf && s_axis_app_tx_data.last;
    assign in_beat   = {s_axis_app_tx_data.data, s_axis_app_tx_data.keep, s_axis_app_tx_data.last};
    assign push_meta = {cnt_nxt + 16'd8, dest_q};

    // Write FSM: state register
    always_ff @(posedge net_clk or negedge net_aresetn) begin
        if (!net_aresetn) state_q <= IDLE;
        else              state_q <= state_d;
    end

    // Write FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (dest_hs) state_d = RECV;
            RECV: begin
                if (recv_beat) begin
                    if (ovf)                            state_d = s_axis_app_tx_data.last ? IDLE : DROP;
                    else if (s_axis_app_tx_data.last)   state_d = IDLE;
                end
            end
            DROP: if (beat_hs && s_axis_app_tx_data.last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write FSM: outputs
    always_comb begin
        dest_rdy = 1'b0;
        data_rdy = 1'b0;
        case (state_q)
            IDLE:    dest_rdy = run_q && !pkt_full;
            RECV:    data_rdy = !buf_full;
            DROP:    data_rdy = 1'b1;
            default: ;
        endcase
    end

    assign s_axis_app_tx_dest.ready = dest_rdy;
    assign s_axis_app_tx_data.ready = data_rdy;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        pkt_start_d = pkt_start_q;
        commit_d    = commit_q;
        byte_cnt_d  = byte_cnt_q;
        dest_d      = dest_q;
        drop_d      = drop_q;
        if (dest_hs) begin
            dest_d      = s_axis_app_tx_dest.data;
            byte_cnt_d  = '0;
            pkt_start_d = wr_ptr_q;
        end
        if (recv_beat) begin
            wr_ptr_d   = wr_ptr_q + PW'(1);
            byte_cnt_d = cnt_nxt;
            if (ovf) begin
                wr_ptr_d = pkt_start_q;
                if (drop_q != 32'hFFFF_FFFF) drop_d = drop_q + 32'd1;
            end else if (s_axis_app_tx_data.last) begin
                commit_d = wr_ptr_q + PW'(1);
            end
        end
    end

    // Metadata side: descriptor queue drained into a registered output.
    assign meta_pop  = mvld_q && m_axis_udp_tx_metadata.ready;
    assign meta_load = dq_nempty && (!mvld_q || m_axis_udp_tx_metadata.ready);

    always_comb begin
        dq_wp_d   = push ? dq_wp_q + (QW+1)'(1) : dq_wp_q;
        dq_rp_d   = meta_load ? dq_rp_q + (QW+1)'(1) : dq_rp_q;
        mvld_d    = meta_load ? 1'b1 : (meta_pop ? 1'b0 : mvld_q);
        mdat_d    = meta_load ? dq_mem[dq_rp_q[QW-1:0]] : mdat_q;
        pkt_cnt_d = pkt_cnt_q + (QW+1)'(push) - (QW+1)'(meta_pop);
    end

    assign m_axis_udp_tx_metadata.valid = mvld_q;
    assign m_axis_udp_tx_metadata.data  = mdat_q;

    // Data side: the buffer read lands straight in a 2-entry output FIFO
    // (output register + skid); a pop this cycle frees room for a new read.
    assign od_pop   = (od_cnt_q != 2'd0) && m_axis_udp_tx_data.ready;
    assign rd_issue = !buf_empty && ((od_cnt_q != 2'd2) || od_pop);

    always_comb begin
        rd_ptr_d = rd_issue ? rd_ptr_q + PW'(1) : rd_ptr_q;
        od_wp_d  = rd_issue ? ~od_wp_q : od_wp_q;
        od_rp_d  = od_pop ? ~od_rp_q : od_rp_q;
        od_cnt_d = od_cnt_q + 2'(rd_issue) - 2'(od_pop);
    end

    assign m_axis_udp_tx_data.valid = (od_cnt_q != 2'd0);
    assign m_axis_udp_tx_data.data  = od_mem[od_rp_q].data;
    assign m_axis_udp_tx_data.keep  = od_mem[od_rp_q].keep;
    assign m_axis_udp_tx_data.last  = od_mem[od_rp_q].last;
    assign drop_count               = drop_q;

    always_ff @(posedge net_clk or negedge net_aresetn) begin
        if (!net_aresetn) begin
            run_q       <= 1'b0;
            wr_ptr_q    <= '0;
            pkt_start_q <= '0;
            commit_q    <= '0;
            rd_ptr_q    <= '0;
            byte_cnt_q  <= '0;
            dest_q      <= '0;
            drop_q      <= '0;
            dq_wp_q     <= '0;
            dq_rp_q     <= '0;
            pkt_cnt_q   <= '0;
            mvld_q      <= 1'b0;
            mdat_q      <= '0;
            od_cnt_q    <= '0;
            od_wp_q     <= 1'b0;
            od_rp_q     <= 1'b0;
        end else begin
            run_q       <= 1'b1;
            wr_ptr_q    <= wr_ptr_d;
            pkt_start_q <= pkt_start_d;
            commit_q    <= commit_d;
            rd_ptr_q    <= rd_ptr_d;
            byte_cnt_q  <= byte_cnt_d;
            dest_q      <= dest_d;
            drop_q      <= drop_d;
            dq_wp_q     <= dq_wp_d;
            dq_rp_q     <= dq_rp_d;
            pkt_cnt_q   <= pkt_cnt_d;
            mvld_q      <= mvld_d;
            mdat_q      <= mdat_d;
            od_cnt_q    <= od_cnt_d;
            od_wp_q     <= od_wp_d;
            od_rp_q     <= od_rp_d;
        end
    end

    // Storage carries no reset; pointers alone decide what is visible.
    always_ff @(posedge net_clk) begin
        if (recv_beat) mem[wr_ptr_q[AW-1:0]]    <= in_beat;
        if (push)      dq_mem[dq_wp_q[QW-1:0]]  <= push_meta;
        if (rd_issue)  od_mem[od_wp_q]          <= mem[rd_ptr_q[AW-1:0]];
    end
endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Bench for udp_tx_packetizer: table of packet vectors, hand-written corner
// sequences, and a scoreboard checking metadata and payload in order.
module tb_udp_tx_packetizer;
    localparam int W = 64;
    localparam logic [159:0] D1 = {16'h5678, 16'h1234, 128'h0A000002};
    localparam logic [159:0] D2 = {16'h0035, 16'hC000, 128'hC0A80001};
    localparam logic [159:0] D3 = {16'h1F90, 16'h8001, 128'h0A0A0A0A};
    localparam logic [159:0] D4 = {16'hFFFF, 16'h0001, 128'hDEADBEEF_00000000_12345678_9ABCDEF0};

    logic        net_clk;
    logic        net_aresetn;
    logic [31:0] drop_count;

    udp_stream_if #(.DW(160))   dest_if ();
    udp_data_if   #(.WIDTH(W))  din_if ();
    udp_stream_if #(.DW(176))   meta_if ();
    udp_data_if   #(.WIDTH(W))  dout_if ();

    udp_tx_packetizer #(.WIDTH(W), .DEPTH(512), .MAX_PAYLOAD_BYTES(1472), .PKT_DEPTH(4)) dut (
        .net_clk                (net_clk),
        .net_aresetn            (net_aresetn),
        .s_axis_app_tx_dest     (dest_if),
        .s_axis_app_tx_data     (din_if),
        .m_axis_udp_tx_metadata (meta_if),
        .m_axis_udp_tx_data     (dout_if),
        .drop_count             (drop_count)
    );

    typedef struct {
        int           nbytes;
        logic [159:0] desc;
        bit           fwd;
        logic [15:0]  len;
        int           drops;
    } vec_t;

    vec_t         vt [7];
    int           n_chk, n_fail, meta_seen, beat_seen, exp_drops;
    int           meta_mode, data_mode;
    logic [175:0] exp_meta [$];
    logic [72:0]  exp_beat [$];

    initial net_clk = 1'b0;
    always #5 net_clk = ~net_clk;

    initial begin
        #950000;
        $display("FAIL watchdog: time limit reached, %0d checks %0d failures", n_chk, n_fail);
        $fatal(1);
    end

    task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    // Output readiness: 0 = held low, 1 = held high, 2 = random per cycle.
    initial begin
        meta_if.ready = 1'b0;
        dout_if.ready = 1'b0;
        forever begin
            @(posedge net_clk); #1;
            meta_if.ready = (meta_mode == 2) ? 1'($urandom_range(0, 1)) : (meta_mode == 1);
            dout_if.ready = (data_mode == 2) ? 1'($urandom_range(0, 1)) : (data_mode == 1);
        end
    end

    always @(negedge net_clk) begin
        if (meta_if.valid && meta_if.ready) begin
            meta_seen++;
            if (exp_meta.size() == 0) fail("meta_unexpected");
            else check("meta", meta_if.data, exp_meta.pop_front());
        end
        if (dout_if.valid && dout_if.ready) begin
            beat_seen++;
            if (exp_beat.size() == 0) fail("beat_unexpected");
            else check("beat", {dout_if.data, dout_if.keep, dout_if.last}, exp_beat.pop_front());
        end
    end

    task automatic drive_desc(input logic [159:0] d);
        bit ok = 1'b0;
        dest_if.valid = 1'b1;
        dest_if.data  = d;
        for (int n = 0; n < 4000 && !ok; n++) begin
            @(negedge net_clk);
            ok = dest_if.ready;
        end
        if (!ok) fail("dest_handshake_timeout");
        @(posedge net_clk); #1;
        dest_if.valid = 1'b0;
    endtask

    task automatic drive_beat(input logic [63:0] dat, input logic [7:0] k, input logic l);
        bit ok = 1'b0;
        din_if.valid = 1'b1;
        din_if.data  = dat;
        din_if.keep  = k;
        din_if.last  = l;
        for (int n = 0; n < 4000 && !ok; n++) begin
            @(negedge net_clk);
            ok = din_if.ready;
        end
        if (!ok) fail("data_handshake_timeout");
        @(posedge net_clk); #1;
        din_if.valid = 1'b0;
        din_if.last  = 1'b0;
    endtask

    task automatic send_pkt(input logic [159:0] d, input int nbytes, input bit fwd,
                            input logic [15:0] len, input bit gaps);
        int          nb;
        int          rem;
        logic [7:0]  k;
        logic [63:0] dat;
        logic        l;
        nb = (nbytes + 7) / 8;
        if (fwd) exp_meta.push_back({len, d});
        else     exp_drops++;
        drive_desc(d);
        for (int i = 0; i < nb; i++) begin
            rem = nbytes - 8 * i;
            k   = (rem >= 8) ? 8'hFF : 8'((16'd1 << rem) - 16'd1);
            dat = {$urandom, $urandom};
            l   = (i == nb - 1);
            if (fwd) exp_beat.push_back({dat, k, l});
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge net_clk); #1;
            end
            drive_beat(dat, k, l);
        end
    endtask

    task automatic wait_drain(input string nm);
        bit ok = 1'b0;
        for (int n = 0; n < 30000 && !ok; n++) begin
            @(posedge net_clk); #1;
            ok = (exp_meta.size() == 0) && (exp_beat.size() == 0);
        end
        check(nm, ok, 1);
        repeat (10) @(posedge net_clk);
        #1;
    endtask

    initial begin
        bit          ok;
        int          m0;
        int          nbytes;
        logic [159:0] rd;

        vt[0] = '{20,   D1, 1'b1, 16'd28,   0};
        vt[1] = '{1480, D2, 1'b0, 16'd0,    1};
        vt[2] = '{8,    D3, 1'b1, 16'd16,   1};
        vt[3] = '{1472, D4, 1'b1, 16'd1480, 1};
        vt[4] = '{2000, D2, 1'b0, 16'd0,    2};
        vt[5] = '{1473, D3, 1'b0, 16'd0,    3};
        vt[6] = '{1,    D4, 1'b1, 16'd9,    3};

        n_chk = 0; n_fail = 0; meta_seen = 0; beat_seen = 0; exp_drops = 0;
        meta_mode = 1; data_mode = 1;
        dest_if.valid = 1'b0; dest_if.data = '0;
        din_if.valid = 1'b0; din_if.data = '0; din_if.keep = '0; din_if.last = 1'b0;

        // Reset state
        net_aresetn = 1'b1;
        #3 net_aresetn = 1'b0;
        #1;
        check("rst_meta_valid", meta_if.valid, 0);
        check("rst_data_valid", dout_if.valid, 0);
        check("rst_dest_ready", dest_if.ready, 0);
        check("rst_data_ready", din_if.ready, 0);
        check("rst_drop_count", drop_count, 0);
        repeat (3) @(posedge net_clk);
        #1 net_aresetn = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 5 && !ok; n++) begin
            @(negedge net_clk);
            ok = dest_if.ready;
        end
        check("dest_ready_after_reset", ok, 1);
        @(posedge net_clk); #1;

        // Table-driven packets, outputs always ready
        foreach (vt[i]) begin
            send_pkt(vt[i].desc, vt[i].nbytes, vt[i].fwd, vt[i].len, 1'b0);
            wait_drain($sformatf("drain_vec%0d", i));
            check($sformatf("drop_count_vec%0d", i), drop_count, vt[i].drops);
        end

        // Latency: both outputs valid two cycles after the last handshake
        send_pkt(D1, 8, 1'b1, 16'd16, 1'b0);
        check("lat_meta_early", meta_if.valid, 0);
        check("lat_data_early", dout_if.valid, 0);
        @(posedge net_clk); #1;
        check("lat_meta_valid", meta_if.valid, 1);
        check("lat_data_valid", dout_if.valid, 1);
        wait_drain("drain_latency");

        // Descriptor queue fills with outputs stalled
        meta_mode = 0; data_mode = 0;
        repeat (2) @(posedge net_clk);
        #1;
        for (int p = 0; p < 4; p++) send_pkt(D3, 64, 1'b1, 16'd72, 1'b0);
        repeat (2) @(posedge net_clk);
        #1;
        m0 = meta_seen;
        dest_if.valid = 1'b1;
        dest_if.data  = D4;
        ok = 1'b0;
        repeat (6) begin
            @(negedge net_clk);
            if (dest_if.ready) ok = 1'b1;
        end
        check("qfull_dest_blocked", ok, 0);
        check("qfull_meta_valid", meta_if.valid, 1);
        @(posedge net_clk); #1;
        dest_if.valid = 1'b0;
        meta_mode = 1;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge net_clk);
            ok = dest_if.ready;
        end
        check("qfull_ready_after_pop", ok, 1);
        check("qfull_meta_popped", meta_seen > m0, 1);
        @(posedge net_clk); #1;
        send_pkt(D4, 64, 1'b1, 16'd72, 1'b0);
        data_mode = 1;
        wait_drain("drain_qfull");

        // Random traffic across pointer wrap with random output readiness
        meta_mode = 2; data_mode = 2;
        for (int p = 0; p < 200; p++) begin
            nbytes = ($urandom_range(0, 19) == 0) ? $urandom_range(1473, 1700) : $urandom_range(1, 600);
            rd     = {16'($urandom), 16'($urandom), $urandom, $urandom, $urandom, $urandom};
            send_pkt(rd, nbytes, nbytes <= 1472, 16'(nbytes + 8), 1'b1);
        end
        meta_mode = 1; data_mode = 1;
        wait_drain("drain_random");
        check("random_drop_count", drop_count, exp_drops);

        // Reset in the middle of a packet
        meta_mode = 0; data_mode = 0;
        send_pkt(D1, 16, 1'b1, 16'd24, 1'b0);
        repeat (3) @(posedge net_clk);
        #1;
        check("pre_rst_meta_valid", meta_if.valid, 1);
        check("pre_rst_data_valid", dout_if.valid, 1);
        drive_desc(D2);
        drive_beat(64'h1111_2222_3333_4444, 8'hFF, 1'b0);
        din_if.valid = 1'b1;
        din_if.data  = 64'h5555_6666_7777_8888;
        din_if.keep  = 8'hFF;
        @(negedge net_clk);
        check("mid_recv_ready", din_if.ready, 1);
        net_aresetn = 1'b0;
        #1;
        check("midrst_meta_valid", meta_if.valid, 0);
        check("midrst_data_valid", dout_if.valid, 0);
        check("midrst_dest_ready", dest_if.ready, 0);
        check("midrst_data_ready", din_if.ready, 0);
        din_if.valid = 1'b0;
        exp_meta.delete();
        exp_beat.delete();
        exp_drops = 0; meta_seen = 0; beat_seen = 0;
        @(posedge net_clk); #1;
        check("midrst_drop_count", drop_count, 0);
        @(posedge net_clk); #1;
        net_aresetn = 1'b1;
        meta_mode = 1; data_mode = 1;
        repeat (3) @(posedge net_clk);
        #1;
        send_pkt(D3, 24, 1'b1, 16'd32, 1'b0);
        wait_drain("drain_after_reset");
        check("post_rst_beats", beat_seen, 3);
        check("post_rst_metas", meta_seen, 1);
        check("post_rst_drop_count", drop_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/udp_tx_packetizer.md
Name: udp_tx_packetizer

Overview:
- Store-and-forward stage directly upstream of the UDP/IP stack TX path, in the net_clk domain.
- Accepts an application payload stream plus a per-packet destination descriptor. Buffers each whole packet, counts its payload bytes, then emits the UDP TX metadata (including length) and the buffered payload.
- Drops payloads larger than MAX_PAYLOAD_BYTES whole, so the stack never sees a partial or oversize datagram.

Parameters:
- WIDTH, 64, data bus width in bits; keep width is WIDTH/8.
- DEPTH, 512, payload buffer depth in WIDTH-bit beats; power of 2, at least 2*ceil(MAX_PAYLOAD_BYTES*8/WIDTH).
- MAX_PAYLOAD_BYTES, 1472, largest accepted UDP payload.
- PKT_DEPTH, 4, committed-packet descriptor queue depth; power of 2.

Ports:
- net_clk  in  1  clock.
- net_aresetn  in  1  asynchronous active-low reset.
- s_axis_app_tx_dest_valid/ready/data  in/out/in  1/1/160  descriptor {dst_port[159:144], src_port[143:128], dst_ip[127:0]}.
- s_axis_app_tx_data_valid/ready/data/keep/last  in/out/in/in/in  1/1/WIDTH/WIDTH/8/1  payload stream.
- m_axis_udp_tx_metadata_valid/ready/data  out/in/out  1/1/176  {length[175:160], dst_port, src_port, dst_ip}.
- m_axis_udp_tx_data_valid/ready/data/keep/last  out/in/out/out/out  1/1/WIDTH/WIDTH/8/1  buffered payload.
- drop_count  out  32  number of dropped oversize packets; saturates at 0xFFFFFFFF.

Behaviour:
- Reset: all valids 0, all readys 0 while net_aresetn low, drop_count 0, pointers 0, FSM IDLE. Reset mid-packet discards all buffered and partially received data.
- Write FSM states: IDLE, RECV, DROP.
- IDLE: dest_ready=1 when the descriptor queue is not full. On descriptor handshake, latch the descriptor, clear byte_cnt, set pkt_start=wr_ptr, go to RECV.
- RECV: data_ready=1 while the buffer is not full. On each beat, write {data,keep,last} at wr_ptr and add popcount(keep) to byte_cnt (keep is contiguous from bit 0).
  - If the new byte_cnt exceeds MAX_PAYLOAD_BYTES: set wr_ptr=pkt_start (rollback), increment drop_count, then go IDLE if the beat has last, else go DROP.
  - On last without overflow: push {byte_cnt+8 (UDP header), descriptor} to the descriptor queue, set commit_ptr=wr_ptr+1, go IDLE.
- DROP: data_ready=1 and beats are discarded; on last go IDLE.
- Buffer full in RECV: data_ready=0 (backpressure). This is unreachable with legal DEPTH and a single in-flight oversize packet, but must stall, never overwrite.
- Read side: the data output reads only beats strictly before commit_ptr, so uncommitted beats are never visible.
  - Metadata and data outputs are independent: metadata valid whenever the descriptor queue is non-empty, data valid whenever rd_ptr != commit_ptr.
  - Buffer read latency 1 cycle, with an output register plus skid so data_valid can assert every cycle under ready=1 (full throughput).
- Order: the k-th metadata always corresponds to the k-th data packet.
- Latency: first output metadata valid 2 cycles after the input last handshake; first output data beat 2 cycles after the input last handshake.
- Pointers are log2(DEPTH)+1 bits: full when MSBs differ and the rest are equal; empty when equal. Wrap-around is transparent.
- A write commit and a read on the same cycle are both honoured.
- Zero-payload packets are not supported: the first data beat must have a non-zero keep.

Test Plan:
- Descriptor {ip=0x0A000002, src=0x1234, dst=0x5678}; 3 beats, keep FF,FF,0F -> metadata length=28 (0x001C), ports and ip echoed; 3 identical output beats with last on beat 3; drop_count=0.
- 1480-byte payload (185 beats, keep FF) -> no metadata, no output data, drop_count=1. A following 8-byte packet is forwarded with length=16.
- Payload of exactly 1472 bytes (184 beats) -> forwarded with length=1480.
- 4 back-to-back 64-byte packets with m_axis metadata ready and data ready held 0 -> descriptor queue fills, and dest_ready=0 for the 5th descriptor until one metadata pops.
- Random ready toggling on both outputs over 200 packets spanning pointer wrap -> bit-exact payload and in-order metadata versus a scoreboard.
- Reset asserted mid-RECV of beat 2 -> all valids 0 immediately. After release, a new packet is forwarded cleanly with no stale beats.
